dcsk_frame_modulator: RTL and testbench

- Parametrised successor to the single-bit DCSK serial modulator.
- Modulates multi-bit signed chaos samples, one message bit per frame.
- Each frame is a reference half (raw chaos) followed by an information half (reference replayed, negated when msg=0).
- Generates frame timing internally and handshakes message bits. Sits between the chaos generator and the TX pulse-shaping/DAC path.

---
 rtl/dcsk_frame_modulator.sv | 154 +++++++++++++++
 tb/tb_dcsk_frame_modulator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcsk_frame_modulator.sv
// DCSK frame modulator for multi-bit signed chaos samples.
// Each accepted message bit produces one frame of SF = 2^sf_log2 samples: a reference half that
// passes the raw chaos samples through, then an information half that replays the stored
// reference, negated (with saturation) when the message bit is 0.
//
// Ports:
//   i_clk, i_arst_n              clock, asynchronous active-low reset
//   i_msg_bit/i_msg_valid        message bit handshake input; o_msg_ready accepts
//   i_sf_log2                    log2 of spreading factor, sampled on message acceptance
//   o_chaos_rd, i_chaos          chaos pull strobe and sample (consumed when strobe is high)
//   o_mod_data, o_mod_valid      registered modulated sample stream
//   o_frame_half, o_frame_start  0 = reference / 1 = information half; first sample of frame
//   o_sf_err                     i_sf_log2 illegal while a message could be accepted
//   o_busy                       a frame is in progress
module dcsk_frame_modulator #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_SF_LOG2 = 5,
  parameter int unsigned SF_W        = $clog2(MAX_SF_LOG2 + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_msg_bit,
  input  logic                     i_msg_valid,
  output logic                     o_msg_ready,
  input  logic [SF_W-1:0]          i_sf_log2,
  output logic                     o_chaos_rd,
  input  logic signed [DATA_W-1:0] i_chaos,
  output logic signed [DATA_W-1:0] o_mod_data,
  output logic                     o_mod_valid,
  output logic                     o_frame_half,
  output logic                     o_frame_start,
  output logic                     o_sf_err,
  output logic                     o_busy
);

  localparam int unsigned CntW  = MAX_SF_LOG2 - 1;
  localparam int unsigned Depth = 1 << CntW;

  localparam logic [SF_W-1:0] SfMin = SF_W'(2);
  localparam logic [SF_W-1:0] SfMax = SF_W'(MAX_SF_LOG2);

  localparam logic signed [DATA_W-1:0] MinVal = {1'b1, {(DATA_W - 1) {1'b0}}};
  localparam logic signed [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W - 1) {1'b1}}};

  typedef enum logic [1:0] {StIdle, StRef, StInfo} state_e;

  state_e                     state_q;
  logic [CntW-1:0]            cnt_q;
  logic [CntW-1:0]            hlast_q;  // half length minus one
  logic                       msg_q;
  logic signed [DATA_W-1:0]   ref_mem_q [Depth];
  logic signed [DATA_W-1:0]   mod_data_q;
  logic                       mod_valid_q;
  logic                       frame_half_q;
  logic                       frame_start_q;

  logic                       sf_ok;
  logic                       last;
  logic                       open;
  logic                       accept;
  logic [CntW-1:0]            hlast_new;
  logic signed [DATA_W-1:0]   ref_sample;
  logic signed [DATA_W-1:0]   info_sample;

  always_comb begin
    sf_ok       = (i_sf_log2 >= SfMin) && (i_sf_log2 <= SfMax);
    last        = (cnt_q == hlast_q);
    // A new message may only be taken while idle or on the final information cycle.
    open        = (state_q == StIdle) || ((state_q == StInfo) && last);
    // Gating with the reset keeps handshake outputs low while reset is held.
    o_msg_ready = i_arst_n & sf_ok & open;
    o_sf_err    = i_arst_n & ~sf_ok & open;
    accept      = i_msg_valid & o_msg_ready;
    // H-1 = 2^(sf_log2-1)-1 as a run of ones; only meaningful when sf_ok.
    hlast_new   = ~({CntW{1'b1}} << (i_sf_log2 - SF_W'(1)));
    ref_sample  = ref_mem_q[cnt_q];
    if (msg_q) begin
      info_sample = ref_sample;
    end else if (ref_sample == MinVal) begin
      info_sample = MaxVal;
    end else begin
      info_sample = -ref_sample;
    end
    o_chaos_rd  = (state_q == StRef);
    o_busy      = (state_q != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      hlast_q       <= '0;
      msg_q         <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        ref_mem_q[i] <= '0;
      end
      mod_data_q    <= '0;
      mod_valid_q   <= 1'b0;
      frame_half_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      mod_data_q    <= '0;
      mod_valid_q   <= 1'b0;
      frame_half_q  <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            msg_q   <= i_msg_bit;
            hlast_q <= hlast_new;
            cnt_q   <= '0;
            state_q <= StRef;
          end
        end
        StRef: begin
          ref_mem_q[cnt_q] <= i_chaos;
          mod_data_q       <= i_chaos;
          mod_valid_q      <= 1'b1;
          frame_start_q    <= (cnt_q == '0);
          if (last) begin
            cnt_q   <= '0;
            state_q <= StInfo;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StInfo: begin
          mod_data_q   <= info_sample;
          mod_valid_q  <= 1'b1;
          frame_half_q <= 1'b1;
          if (last) begin
            cnt_q <= '0;
            if (accept) begin
              msg_q   <= i_msg_bit;
              hlast_q <= hlast_new;
              state_q <= StRef;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_mod_data    = mod_data_q;
  assign o_mod_valid   = mod_valid_q;
  assign o_frame_half  = frame_half_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_dcsk_frame_modulator.sv
// Directed self-checking bench for dcsk_frame_modulator.
module tb_dcsk_frame_modulator;

  localparam int DataW = 8;
  localparam int MaxSf = 5;
  localparam int SfW   = 3;

  logic                    clk       = 1'b0;
  logic                    arst_n    = 1'b0;
  logic                    msg_bit   = 1'b0;
  logic                    msg_valid = 1'b0;
  logic                    msg_ready;
  logic [SfW-1:0]          sf        = 3'd2;
  logic                    chaos_rd;
  logic signed [DataW-1:0] chaos     = '0;
  logic signed [DataW-1:0] mod_data;
  logic                    mod_valid;
  logic                    frame_half;
  logic                    frame_start;
  logic                    sf_err;
  logic                    busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Back-to-back SF8 (msg 1) then SF4 (msg 0) table, indexed by cycle after acceptance.
  int t3_chaos [14] = '{1, 2, 3, 4, 0, 0, 0, 0, 7, -8, 0, 0, 0, 0};
  int t3_ready [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
  int t3_rd    [14] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  int t3_busy  [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int t3_valid [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int t3_data  [14] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 7, -8, -7, 8, 0};
  int t3_half  [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0};
  int t3_start [14] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  dcsk_frame_modulator #(
    .DATA_W     (DataW),
    .MAX_SF_LOG2(MaxSf),
    .SF_W       (SfW)
  ) dut (
    .i_clk        (clk),
    .i_arst_n     (arst_n),
    .i_msg_bit    (msg_bit),
    .i_msg_valid  (msg_valid),
    .o_msg_ready  (msg_ready),
    .i_sf_log2    (sf),
    .o_chaos_rd   (chaos_rd),
    .i_chaos      (chaos),
    .o_mod_data   (mod_data),
    .o_mod_valid  (mod_valid),
    .o_frame_half (frame_half),
    .o_frame_start(frame_start),
    .o_sf_err     (sf_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input int d, input int half, input int start);
    chk({tag, ".valid"}, int'(mod_valid), 1);
    chk({tag, ".data"}, int'(mod_data), d);
    chk({tag, ".half"}, int'(frame_half), half);
    chk({tag, ".start"}, int'(frame_start), start);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic int f4(input int k);
    return k * 13 - 100;
  endfunction

  initial begin
    int rd_cnt;
    int v_cnt;

    // Reset state
    #2;
    chk("rst.valid", int'(mod_valid), 0);
    chk("rst.data", int'(mod_data), 0);
    chk("rst.half", int'(frame_half), 0);
    chk("rst.start", int'(frame_start), 0);
    chk("rst.rd", int'(chaos_rd), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ready", int'(msg_ready), 0);
    chk("rst.sferr", int'(sf_err), 0);
    @(negedge clk);
    #1;
    arst_n = 1'b1;
    #1;
    chk("idle.ready", int'(msg_ready), 1);

    // SF4, msg=1, chaos 10,20
    sf = 3'd2; msg_bit = 1'b1; msg_valid = 1'b1;
    #1;
    chk("t1.ready", int'(msg_ready), 1);
    tick();
    msg_valid = 1'b0; chaos = 8'sd10;
    chk("t1.busy", int'(busy), 1);
    chk("t1.rd0", int'(chaos_rd), 1);
    chk("t1.v0", int'(mod_valid), 0);
    chk("t1.rdy0", int'(msg_ready), 0);
    tick();
    chk_sample("t1.s0", 10, 0, 1);
    chaos = 8'sd20;
    tick();
    chk_sample("t1.s1", 20, 0, 0);
    chk("t1.rd2", int'(chaos_rd), 0);
    chaos = '0;
    tick();
    chk_sample("t1.s2", 10, 1, 0);
    chk("t1.rdylast", int'(msg_ready), 1);
    tick();
    chk_sample("t1.s3", 20, 1, 0);
    chk("t1.idle", int'(busy), 0);
    tick();
    chk("t1.vend", int'(mod_valid), 0);

    // SF4, msg=0, saturating negation
    msg_bit = 1'b0; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0; chaos = -8'sd128;
    tick();
    chk_sample("t2.s0", -128, 0, 1);
    chaos = 8'sd5;
    tick();
    chk_sample("t2.s1", 5, 0, 0);
    chaos = '0;
    tick();
    chk_sample("t2.s2", 127, 1, 0);
    tick();
    chk_sample("t2.s3", -5, 1, 0);
    tick();
    chk("t2.vend", int'(mod_valid), 0);

    // SF8 then SF4 back-to-back, valid held high
    sf = 3'd3; msg_bit = 1'b1; msg_valid = 1'b1;
    #1;
    chk("t3.ready", int'(msg_ready), 1);
    tick();
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("t3.k%0d.ready", k), int'(msg_ready), t3_ready[k]);
      chk($sformatf("t3.k%0d.rd", k), int'(chaos_rd), t3_rd[k]);
      chk($sformatf("t3.k%0d.busy", k), int'(busy), t3_busy[k]);
      if (t3_valid[k] != 0) begin
        chk_sample($sformatf("t3.k%0d", k), t3_data[k], t3_half[k], t3_start[k]);
      end else begin
        chk($sformatf("t3.k%0d.valid", k), int'(mod_valid), 0);
      end
      chaos = 8'(t3_chaos[k]);
      if (k == 7) begin
        sf = 3'd2; msg_bit = 1'b0;
      end
      if (k == 11) msg_valid = 1'b0;
      tick();
    end

    // Illegal spreading factors, then SF32
    sf = 3'd1; msg_bit = 1'b1; msg_valid = 1'b1;
    #1;
    chk("t4.sf1.err", int'(sf_err), 1);
    chk("t4.sf1.ready", int'(msg_ready), 0);
    tick();
    chk("t4.sf1.busy", int'(busy), 0);
    chk("t4.sf1.valid", int'(mod_valid), 0);
    sf = 3'd6;
    #1;
    chk("t4.sf6.err", int'(sf_err), 1);
    chk("t4.sf6.ready", int'(msg_ready), 0);
    tick();
    chk("t4.sf6.busy", int'(busy), 0);
    chk("t4.sf6.valid", int'(mod_valid), 0);
    sf = 3'd5;
    #1;
    chk("t4.sf5.err", int'(sf_err), 0);
    chk("t4.sf5.ready", int'(msg_ready), 1);
    tick();
    msg_valid = 1'b0;
    for (int k = 0; k < 33; k++) begin
      if (k >= 1) begin
        chk_sample($sformatf("t4.j%0d", k - 1), f4((k - 1) % 16), ((k - 1) >= 16) ? 1 : 0,
                   (k == 1) ? 1 : 0);
      end
      chk($sformatf("t4.k%0d.rd", k), int'(chaos_rd), (k < 16) ? 1 : 0);
      chaos = (k < 16) ? 8'(f4(k)) : '0;
      if (k == 16) sf = 3'd7;
      if (k == 31) begin
        #1;
        chk("t4.last.err", int'(sf_err), 1);
        chk("t4.last.ready", int'(msg_ready), 0);
      end
      if (k == 32) chk("t4.idle", int'(busy), 0);
      if (k < 32) tick();
    end
    tick();
    chk("t4.vend", int'(mod_valid), 0);
    chk("t4.idle.err", int'(sf_err), 1);

    // Reset during INFO of an SF16 frame
    sf = 3'd4; msg_bit = 1'b0; msg_valid = 1'b1;
    #1;
    chk("t5.err", int'(sf_err), 0);
    tick();
    msg_valid = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chaos = 8'(k + 1);
      tick();
    end
    chk_sample("t5.pre", -3, 1, 0);
    arst_n = 1'b0;
    #1;
    chk("t5.rst.valid", int'(mod_valid), 0);
    chk("t5.rst.data", int'(mod_data), 0);
    chk("t5.rst.half", int'(frame_half), 0);
    chk("t5.rst.start", int'(frame_start), 0);
    chk("t5.rst.rd", int'(chaos_rd), 0);
    chk("t5.rst.busy", int'(busy), 0);
    chk("t5.rst.ready", int'(msg_ready), 0);
    tick();
    arst_n = 1'b1;
    #1;
    chk("t5.rel.busy", int'(busy), 0);
    chk("t5.rel.ready", int'(msg_ready), 1);
    chk("t5.rel.valid", int'(mod_valid), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5.post%0d.valid", k), int'(mod_valid), 0);
      chk($sformatf("t5.post%0d.busy", k), int'(busy), 0);
    end

    // i_sf_log2 toggled during an SF8 frame
    sf = 3'd3; msg_bit = 1'b1; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    rd_cnt = 0;
    v_cnt  = 0;
    for (int k = 0; k < 14; k++) begin
      if (chaos_rd) rd_cnt++;
      if (mod_valid) v_cnt++;
      chaos = 8'(k);
      sf = 3'(k * 3);
      tick();
    end
    chk("t6.rdcount", rd_cnt, 4);
    chk("t6.validcount", v_cnt, 8);
    chk("t6.busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
